// File: rtl/sram_resp_pkg.sv
// Shared types and helpers for the SRAM responder.
// Optional collision bypass is selected with SRAM_BYPASS_EN.
package sram_resp_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam int          ADDR_W_DEF     = 10;
  localparam logic [31:0] INIT_VALUE_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_idx(
    input logic [31:0] addr
  );
    return addr >> 2;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// CPU-side inst/data SRAM ports, debug read port and init flag.
// master = CPU/SoC side, slave = memory responder.
interface sram_responder_if;

  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  logic [31:0] dbg_addr;
  logic [31:0] dbg_data;
  logic        init_done;

  modport master (
    output inst_sram_en,
    output inst_sram_wen,
    output inst_sram_addr,
    output inst_sram_wdata,
    input  inst_sram_rdata,
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata,
    output dbg_addr,
    input  dbg_data,
    input  init_done
  );

  modport slave (
    input  inst_sram_en,
    input  inst_sram_wen,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    output inst_sram_rdata,
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata,
    input  dbg_addr,
    output dbg_data,
    output init_done
  );

endinterface

// File: rtl/sram_lane_merge.sv
// Byte-lane merge of an old word with data and inst writes.
// Data-port lanes win where both ports write.
module sram_lane_merge (
  input  logic [31:0] i_old,
  input  logic [3:0]  i_d_wen,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_i_wen,
  input  logic [31:0] i_i_wdata,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = i_old;
    for (int b = 0; b < 4; b++) begin
      if (i_i_wen[b])
        o_word[8*b +: 8] = i_i_wdata[8*b +: 8];
      if (i_d_wen[b])
        o_word[8*b +: 8] = i_d_wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Dual-port word SRAM responder with post-reset clear sweep.
// Define SRAM_BYPASS_EN to forward cross-port writes to readers.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int          ADDR_W     = ADDR_W_DEF,
  parameter logic [31:0] INIT_VALUE = INIT_VALUE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  sram_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  typedef logic [ADDR_W-1:0] idx_t;

  state_t      r_state;
  state_t      w_state_nxt;
  idx_t        r_clr_idx;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic [31:0] r_dbg;

  idx_t        w_i_idx;
  idx_t        w_d_idx;
  idx_t        w_g_idx;
  logic        w_act;
  logic        w_i_en;
  logic        w_d_en;
  logic        w_i_we;
  logic        w_d_we;
  logic        w_same;
  logic        w_init_done;
  logic [3:0]  w_i_wen;
  logic [3:0]  w_d_wen;
  logic [3:0]  w_dm_i_wen;
  logic [31:0] w_d_word;
  logic [31:0] w_i_word;
  logic [31:0] w_i_rd;
  logic [31:0] w_d_rd;
  logic [31:0] w_g_rd;

  assign w_i_idx = idx_t'(word_idx(bus.inst_sram_addr));
  assign w_d_idx = idx_t'(word_idx(bus.data_sram_addr));
  assign w_g_idx = idx_t'(word_idx(bus.dbg_addr));

  // A reset edge must not let port traffic touch the array.
  assign w_act   = (r_state == S_READY) && !reset;
  assign w_i_en  = w_act && bus.inst_sram_en;
  assign w_d_en  = w_act && bus.data_sram_en;
  assign w_i_wen = w_i_en ? bus.inst_sram_wen : 4'b0;
  assign w_d_wen = w_d_en ? bus.data_sram_wen : 4'b0;
  assign w_i_we  = |w_i_wen;
  assign w_d_we  = |w_d_wen;
  assign w_same  = (w_i_idx == w_d_idx);

  assign w_dm_i_wen = w_same ? w_i_wen : 4'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR)
        r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_CLEAR: if (&r_clr_idx) w_state_nxt = S_READY;
      S_READY: w_state_nxt = S_READY;
    endcase
  end

  always_comb begin
    w_init_done = (r_state == S_READY);
  end

  sram_lane_merge u_merge_d (
    .i_old     (r_mem[w_d_idx]),
    .i_d_wen   (w_d_wen),
    .i_d_wdata (bus.data_sram_wdata),
    .i_i_wen   (w_dm_i_wen),
    .i_i_wdata (bus.inst_sram_wdata),
    .o_word    (w_d_word)
  );

  sram_lane_merge u_merge_i (
    .i_old     (r_mem[w_i_idx]),
    .i_d_wen   (4'b0),
    .i_d_wdata (bus.data_sram_wdata),
    .i_i_wen   (w_i_wen),
    .i_i_wdata (bus.inst_sram_wdata),
    .o_word    (w_i_word)
  );

  // Same-word dual write lands once, as the data-side merged word.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_idx] <= INIT_VALUE;
    end else begin
      if (w_d_we)
        r_mem[w_d_idx] <= w_d_word;
      if (w_i_we && !(w_same && w_d_we))
        r_mem[w_i_idx] <= w_i_word;
    end
  end

`ifdef SRAM_BYPASS_EN
  always_comb begin
    w_i_rd = r_mem[w_i_idx];
    if (w_same && w_d_we)
      w_i_rd = w_d_word;
    w_d_rd = r_mem[w_d_idx];
    if (w_same && w_i_we)
      w_d_rd = w_d_we ? w_d_word : w_i_word;
    w_g_rd = r_mem[w_g_idx];
    if (w_i_we && (w_g_idx == w_i_idx))
      w_g_rd = w_i_word;
    if (w_d_we && (w_g_idx == w_d_idx))
      w_g_rd = w_d_word;
  end
`else
  assign w_i_rd = r_mem[w_i_idx];
  assign w_d_rd = r_mem[w_d_idx];
  assign w_g_rd = r_mem[w_g_idx];
`endif

  always_ff @(posedge clk) begin
    if (!w_act) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_dbg     <= '0;
    end else begin
      if (w_i_en)
        r_i_rdata <= w_i_rd;
      if (w_d_en)
        r_d_rdata <= w_d_rd;
      r_dbg <= w_g_rd;
    end
  end

  assign bus.inst_sram_rdata = r_i_rdata;
  assign bus.data_sram_rdata = r_d_rdata;
  assign bus.dbg_data        = r_dbg;
  assign bus.init_done       = w_init_done;

endmodule
